// File: rtl/rtc_param_clock.sv
// Real-time clock core: prescaled 1 Hz tick, binary HH:MM:SS with runtime set,
// minute-resolution alarm, day rollover and six 7-segment digit outputs (12/24 h).
module rtc_param_clock #(
  parameter int TICKS_PER_SEC  = 50_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hr,
  input  logic [5:0] alarm_min,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       alarm_hit,
  output logic       set_err,
  output logic       pm,
  output logic [6:0] hrm,
  output logic [6:0] hrl,
  output logic [6:0] min_m,
  output logic [6:0] min_l,
  output logic [6:0] sec_m,
  output logic [6:0] sec_l
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [4:0]    hr;
  logic [5:0]    min, sec;

  // set_valid is a single-cycle strobe with no ready: it is always accepted
  // (loaded when all fields are in range, otherwise answered with set_err).
  logic set_ok, do_load, tick;
  assign set_ok  = (set_hr < 5'd24) && (set_min < 6'd60) && (set_sec < 6'd60);
  assign do_load = set_valid && set_ok;
  assign tick    = (presc == P_LAST);

  logic [4:0] nhr;
  logic [5:0] nmin, nsec;
  logic       day_wrap, alarm_match;

  always_comb begin
    nsec     = sec + 6'd1;
    nmin     = min;
    nhr      = hr;
    day_wrap = 1'b0;
    if (sec == 6'd59) begin
      nsec = 6'd0;
      nmin = min + 6'd1;
      if (min == 6'd59) begin
        nmin = 6'd0;
        nhr  = hr + 5'd1;
        if (hr == 5'd23) begin
          nhr      = 5'd0;
          day_wrap = 1'b1;
        end
      end
    end
  end

  assign alarm_match = alarm_en && (nhr == alarm_hr) && (nmin == alarm_min) && (nsec == 6'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      hr        <= '0;
      min       <= '0;
      sec       <= '0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      alarm_hit <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      alarm_hit <= 1'b0;
      set_err   <= set_valid && !set_ok;
      if (do_load) begin
        // A load wins over a coincident tick; that second is dropped.
        presc <= '0;
        hr    <= set_hr;
        min   <= set_min;
        sec   <= set_sec;
      end else if (tick) begin
        presc     <= '0;
        hr        <= nhr;
        min       <= nmin;
        sec       <= nsec;
        sec_pulse <= 1'b1;
        day_pulse <= day_wrap;
        alarm_hit <= alarm_match;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    if (blank) s = 7'h00;
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  logic [4:0] hr_disp;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;

  always_comb begin
    hr_disp = hr;
    if (mode_12h) begin
      if (hr == 5'd0)      hr_disp = 5'd12;
      else if (hr > 5'd12) hr_disp = hr - 5'd12;
    end
    hr_t  = 4'(hr_disp / 5'd10);
    hr_u  = 4'(hr_disp % 5'd10);
    min_t = 4'(min / 6'd10);
    min_u = 4'(min % 6'd10);
    sec_t = 4'(sec / 6'd10);
    sec_u = 4'(sec % 6'd10);
  end

  assign pm    = (hr >= 5'd12);
  assign hrm   = seg7(hr_t, mode_12h && (hr_t == 4'd0));
  assign hrl   = seg7(hr_u, 1'b0);
  assign min_m = seg7(min_t, 1'b0);
  assign min_l = seg7(min_u, 1'b0);
  assign sec_m = seg7(sec_t, 1'b0);
  assign sec_l = seg7(sec_u, 1'b0);
endmodule

// File: tb/tb_rtc_param_clock.sv
// Bench for rtc_param_clock: seconds-of-day reference model checked every cycle,
// directed literal scenarios, then randomized set/reset/mode/alarm traffic.
module tb_rtc_param_clock;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_12h = 1'b0, set_valid = 1'b0, alarm_en = 1'b0;
  logic [4:0] set_hr = '0, alarm_hr = '0;
  logic [5:0] set_min = '0, set_sec = '0, alarm_min = '0;
  logic       sec_pulse, day_pulse, alarm_hit, set_err, pm;
  logic [6:0] hrm, hrl, min_m, min_l, sec_m, sec_l;
  logic       l_sp, l_dp, l_ah, l_se, l_pm;
  logic [6:0] l_hrm, l_hrl, l_min_m, l_min_l, l_sec_m, l_sec_l;

  int n_vec = 0, n_err = 0;
  int m_tod = 0, m_cnt = 0;
  bit m_sp, m_dp, m_ah, m_se, started;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  rtc_param_clock #(.TICKS_PER_SEC(T), .SEG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_valid(set_valid), .set_hr(set_hr),
    .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en), .alarm_hr(alarm_hr),
    .alarm_min(alarm_min), .sec_pulse(sec_pulse), .day_pulse(day_pulse), .alarm_hit(alarm_hit),
    .set_err(set_err), .pm(pm), .hrm(hrm), .hrl(hrl), .min_m(min_m), .min_l(min_l),
    .sec_m(sec_m), .sec_l(sec_l));

  rtc_param_clock #(.TICKS_PER_SEC(T), .SEG_ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_valid(set_valid), .set_hr(set_hr),
    .set_min(set_min), .set_sec(set_sec), .alarm_en(alarm_en), .alarm_hr(alarm_hr),
    .alarm_min(alarm_min), .sec_pulse(l_sp), .day_pulse(l_dp), .alarm_hit(l_ah),
    .set_err(l_se), .pm(l_pm), .hrm(l_hrm), .hrl(l_hrl), .min_m(l_min_m), .min_l(l_min_l),
    .sec_m(l_sec_m), .sec_l(l_sec_l));

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    if (d < 0) return 7'h00;
    return seg_tab[d];
  endfunction

  // Reference: time of day as a seconds count, prescaler as a plain counter.
  task automatic model_step();
    bit ok;
    if (rst) begin
      m_tod = 0; m_cnt = 0; m_sp = 0; m_dp = 0; m_ah = 0; m_se = 0;
      return;
    end
    m_sp = 0; m_dp = 0; m_ah = 0; m_se = 0;
    ok = (set_hr < 24) && (set_min < 60) && (set_sec < 60);
    if (set_valid && ok) begin
      m_tod = set_hr * 3600 + set_min * 60 + set_sec;
      m_cnt = 0;
    end else begin
      if (set_valid) m_se = 1;
      if (m_cnt == T - 1) begin
        m_cnt = 0;
        m_tod = (m_tod + 1) % 86400;
        m_sp  = 1;
        m_dp  = (m_tod == 0);
        m_ah  = alarm_en && (m_tod == alarm_hr * 3600 + alarm_min * 60);
      end else begin
        m_cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      int h, hd, ht;
      logic [6:0] e [6];
      h  = m_tod / 3600;
      hd = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
      ht = (mode_12h && hd < 10) ? -1 : hd / 10;
      e[0] = seg_of(ht);
      e[1] = seg_of(hd % 10);
      e[2] = seg_of((m_tod / 60) % 60 / 10);
      e[3] = seg_of((m_tod / 60) % 10);
      e[4] = seg_of((m_tod % 60) / 10);
      e[5] = seg_of(m_tod % 10);
      check("hrm", hrm, e[0]);     check("hrl", hrl, e[1]);
      check("min_m", min_m, e[2]); check("min_l", min_l, e[3]);
      check("sec_m", sec_m, e[4]); check("sec_l", sec_l, e[5]);
      check("low_hrm", l_hrm, ~e[0]);     check("low_hrl", l_hrl, ~e[1]);
      check("low_min_m", l_min_m, ~e[2]); check("low_min_l", l_min_l, ~e[3]);
      check("low_sec_m", l_sec_m, ~e[4]); check("low_sec_l", l_sec_l, ~e[5]);
      check("sec_pulse", 7'(sec_pulse), 7'(m_sp));
      check("day_pulse", 7'(day_pulse), 7'(m_dp));
      check("alarm_hit", 7'(alarm_hit), 7'(m_ah));
      check("set_err", 7'(set_err), 7'(m_se));
      check("pm", 7'(pm), 7'(h >= 12));
      check("low_pulses", {3'b0, l_sp, l_dp, l_ah, l_se}, {3'b0, m_sp, m_dp, m_ah, m_se});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      started = 1;
      #1;
    end
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    step(1);
    set_valid = 1'b0;
  endtask

  initial begin
    int guard;
    // Reset and first tick
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst_hrm", hrm, 7'h3F);     check("rst_sec_l", sec_l, 7'h3F);
    check("rst_low_hrm", l_hrm, 7'h40); check("rst_low_sec_l", l_sec_l, 7'h40);
    check("rst_pulse", 7'(sec_pulse), 7'h00);
    step(3);
    check("pre_tick_pulse", 7'(sec_pulse), 7'h00);
    step(1);
    check("tick4_pulse", 7'(sec_pulse), 7'h01);
    check("tick4_sec_l", sec_l, 7'h06);
    step(1);
    check("tick4_pulse_len", 7'(sec_pulse), 7'h00);

    // Day rollover
    do_set(23, 59, 58);
    step(4);
    check("r1_sec_l", sec_l, 7'h6F); check("r1_sec_m", sec_m, 7'h6D);
    check("r1_day", 7'(day_pulse), 7'h00);
    step(4);
    check("r2_hrm", hrm, 7'h3F); check("r2_sec_l", sec_l, 7'h3F);
    check("r2_sp", 7'(sec_pulse), 7'h01); check("r2_day", 7'(day_pulse), 7'h01);

    // 12h display
    mode_12h = 1'b1;
    do_set(0, 0, 0);
    check("h0_hrm", hrm, 7'h06); check("h0_hrl", hrl, 7'h5B); check("h0_pm", 7'(pm), 7'h00);
    do_set(13, 0, 0);
    check("h13_hrm", hrm, 7'h00); check("h13_hrl", hrl, 7'h06); check("h13_pm", 7'(pm), 7'h01);
    check("h13_low_hrm", l_hrm, 7'h7F);
    mode_12h = 1'b0;
    do_set(9, 0, 0);
    check("h9_hrm", hrm, 7'h3F); check("h9_hrl", hrl, 7'h6F);

    // Alarm
    alarm_hr = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
    do_set(7, 29, 59);
    step(4);
    check("al_hit", 7'(alarm_hit), 7'h01); check("al_sp", 7'(sec_pulse), 7'h01);
    step(1);
    check("al_len", 7'(alarm_hit), 7'h00);
    do_set(7, 30, 0);
    check("al_set", 7'(alarm_hit), 7'h00);
    step(4);
    check("al_after_set", 7'(alarm_hit), 7'h00);

    // Invalid set, then set on the terminal prescaler cycle
    step(2);
    do_set(24, 0, 0);
    check("err_pulse", 7'(set_err), 7'h01); check("err_min_l", min_l, 7'h3F);
    step(1);
    check("err_len", 7'(set_err), 7'h00);
    guard = 0;
    while (m_cnt != T - 1 && guard < 10) begin step(1); guard++; end
    check("collide_reach", 7'(m_cnt == T - 1), 7'h01);
    do_set(10, 20, 30);
    check("col_sp", 7'(sec_pulse), 7'h00); check("col_sec_m", sec_m, 7'h4F);
    check("col_hrm", hrm, 7'h06);

    // Randomized traffic
    alarm_hr = 5'($urandom_range(0, 23));
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      set_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: begin set_hr = alarm_hr; set_min = 6'd29; set_sec = 6'($urandom_range(56, 59)); end
        1: begin set_hr = 5'd23; set_min = 6'd59; set_sec = 6'($urandom_range(55, 59)); end
        default: begin
          set_hr = 5'($urandom_range(0, 25)); set_min = 6'($urandom_range(0, 61));
          set_sec = 6'($urandom_range(0, 61));
        end
      endcase
      if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
      if ($urandom_range(0, 399) == 0) alarm_en = ~alarm_en;
      step(1);
    end
    rst = 1'b0; set_valid = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
